// File: rtl/kbd_line_ctrl_pkg.sv
// Purpose: shared ASCII constants, line-editor state type and character classifier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kbd_pkg;

  localparam logic [7:0] ASC_BEL = 8'h07;
  localparam logic [7:0] ASC_BS  = 8'h08;
  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_SP  = 8'h20;
  localparam logic [7:0] ASC_DEL = 8'h7F;

  typedef enum logic {
    EDIT  = 1'b0,
    FLUSH = 1'b1
  } line_state_t;

  // Printable ASCII is SP..'~'; DEL and all control codes are excluded.
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASC_SP) && (c < ASC_DEL);
  endfunction

endpackage

// File: rtl/kbd_line_ctrl_if.sv
// Purpose: completed-line byte stream (valid/ready) between line editor and consumer.
// Latency: n/a (wiring only).
// Backpressure: consumer holds line_ready low to stall; producer holds data/last stable.
// Ports: line_data/line_valid/line_last driven by master, line_ready driven by slave.
interface kbd_line_ctrl_if;
  logic [7:0] line_data;
  logic       line_valid;
  logic       line_ready;
  logic       line_last;

  modport master (output line_data, output line_valid, output line_last, input line_ready);
  modport slave  (input line_data, input line_valid, input line_last, output line_ready);
endinterface

// File: rtl/kbd_line_buf.sv
// Purpose: DEPTH x 8 character store, one synchronous write port, one async read port.
// Latency: write visible on read port the cycle after we; read is combinational.
// Backpressure: none; no reset, contents survive reset.
// Ports: clk, we/waddr/wdata write port, raddr -> rdata read port.
module kbd_line_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  // Sized to the full address space so every raddr value is a legal index;
  // entries at DEPTH and above are never written or selected by the controller.
  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/kbd_line_ctrl.sv
// Purpose: line editor after the PS/2 wrapper: buffers printable chars, handles BS, streams line on CR.
// Latency: echo/drop/count one cycle after char_ready; line output starts the cycle after CR.
// Backpressure: line bytes held stable while line_ready low; chars arriving during a flush are dropped.
// Ports: clk, reset_n, char_data/char_ready in, echo_data/echo_valid out, line (master),
//        busy, drop, count.
module kbd_line_ctrl
  import kbd_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       char_data,
  input  logic             char_ready,
  output logic [7:0]       echo_data,
  output logic             echo_valid,
  kbd_line_ctrl_if.master  line,
  output logic             busy,
  output logic             drop,
  output logic [CW-1:0]    count
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  line_state_t   state_q, state_d;
  logic [CW-1:0] count_q, rd_ptr_q;
  logic [7:0]    echo_data_q;
  logic          echo_valid_q, drop_q;

  logic          we, echo_go, drop_go;
  logic          cnt_inc, cnt_dec, cnt_clr, rd_clr, rd_adv;
  logic [7:0]    echo_byte, rdata;
  logic          more_chars;

  kbd_line_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (count_q[AW-1:0]),
    .wdata (char_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata)
  );

  // rd_ptr == count selects the terminator slot.
  assign more_chars = (rd_ptr_q < count_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= EDIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    we        = 1'b0;
    echo_go   = 1'b0;
    echo_byte = char_data;
    drop_go   = 1'b0;
    cnt_inc   = 1'b0;
    cnt_dec   = 1'b0;
    cnt_clr   = 1'b0;
    rd_clr    = 1'b0;
    rd_adv    = 1'b0;
    case (state_q)
      EDIT: begin
        if (char_ready) begin
          if (is_printable(char_data)) begin
            echo_go = 1'b1;
            if (count_q < DEPTH_C) begin
              we      = 1'b1;
              cnt_inc = 1'b1;
            end else begin
              drop_go   = 1'b1;
              echo_byte = ASC_BEL;
            end
          end else if (char_data == ASC_BS) begin
            if (count_q != '0) begin
              cnt_dec = 1'b1;
              echo_go = 1'b1;
            end
          end else if (char_data == ASC_CR) begin
            echo_go = 1'b1;
            rd_clr  = 1'b1;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        drop_go = char_ready;
        if (line.line_ready) begin
          if (more_chars) begin
            rd_adv = 1'b1;
          end else begin
            cnt_clr = 1'b1;
            state_d = EDIT;
          end
        end
      end
      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      echo_data_q  <= '0;
      echo_valid_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      if (cnt_clr)      count_q <= '0;
      else if (cnt_inc) count_q <= count_q + ONE;
      else if (cnt_dec) count_q <= count_q - ONE;

      if (rd_clr)      rd_ptr_q <= '0;
      else if (rd_adv) rd_ptr_q <= rd_ptr_q + ONE;

      echo_valid_q <= echo_go;
      if (echo_go) echo_data_q <= echo_byte;
      drop_q <= drop_go;
    end
  end

  assign line.line_valid = (state_q == FLUSH);
  assign line.line_data  = more_chars ? rdata : ASC_CR;
  assign line.line_last  = (rd_ptr_q == count_q) && (state_q == FLUSH);
  assign busy            = (state_q == FLUSH);
  assign echo_data       = echo_data_q;
  assign echo_valid      = echo_valid_q;
  assign drop            = drop_q;
  assign count           = count_q;

endmodule

// File: tb/tb_kbd_line_ctrl.sv
// Purpose: directed self-checking bench for kbd_line_ctrl (DEPTH=4).
// Latency: checks echo/drop/count one cycle after each strobe, line bytes per beat.
// Backpressure: exercises stalls, toggling ready, and reset during a flush.
module tb_kbd_line_ctrl;
  import kbd_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    char_data;
  logic          char_ready;
  logic [7:0]    echo_data;
  logic          echo_valid;
  logic          busy, drop;
  logic [CW-1:0] count;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  kbd_line_ctrl_if lif ();

  kbd_line_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .char_data  (char_data),
    .char_ready (char_ready),
    .echo_data  (echo_data),
    .echo_valid (echo_valid),
    .line       (lif),
    .busy       (busy),
    .drop       (drop),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe one char; on return the registered echo/drop/count for it are visible.
  task automatic send(input logic [7:0] c);
    char_data  = c;
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
  endtask

  task automatic send_echo(input string tag, input logic [7:0] c, input logic [7:0] echo_exp,
                           input int cnt_exp);
    send(c);
    chk({tag, "_echo_vld"}, echo_valid, 1);
    chk({tag, "_echo_dat"}, echo_data, echo_exp);
    chk({tag, "_drop"}, drop, 0);
    chk({tag, "_count"}, count, cnt_exp);
  endtask

  // Drain exp_q with line_ready held high: one beat per cycle, last only on the final byte.
  task automatic expect_line(input string tag);
    lif.line_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_vld%0d", tag, i), lif.line_valid, 1);
      chk($sformatf("%s_dat%0d", tag, i), lif.line_data, exp_q[i]);
      chk($sformatf("%s_last%0d", tag, i), lif.line_last, (i == exp_q.size() - 1) ? 1 : 0);
      tick();
    end
    chk({tag, "_done_vld"}, lif.line_valid, 0);
    chk({tag, "_done_busy"}, busy, 0);
    chk({tag, "_done_count"}, count, 0);
  endtask

  initial begin
    reset_n        = 1'b0;
    char_data      = 8'h00;
    char_ready     = 1'b0;
    lif.line_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_echo_vld", echo_valid, 0);
    chk("rst_echo_dat", echo_data, 0);
    chk("rst_line_vld", lif.line_valid, 0);
    chk("rst_line_last", lif.line_last, 0);
    chk("rst_line_dat", lif.line_data, 8'h0D);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    chk("rst_count", count, 0);
    reset_n = 1'b1;
    tick();

    // "AB" CR
    lif.line_ready = 1'b1;
    send_echo("t1_A", 8'h41, 8'h41, 1);
    send_echo("t1_B", 8'h42, 8'h42, 2);
    send_echo("t1_CR", 8'h0D, 8'h0D, 2);
    chk("t1_busy", busy, 1);
    exp_q = '{8'h41, 8'h42, 8'h0D};
    expect_line("t1_line");

    // BS on empty line, then "ABC" BS BS "Z" CR
    send(8'h08);
    chk("t2_bs0_echo_vld", echo_valid, 0);
    chk("t2_bs0_count", count, 0);
    send(8'h01);
    chk("t2_ctl_echo_vld", echo_valid, 0);
    chk("t2_ctl_drop", drop, 0);
    send_echo("t2_A", 8'h41, 8'h41, 1);
    send_echo("t2_B", 8'h42, 8'h42, 2);
    send_echo("t2_C", 8'h43, 8'h43, 3);
    send_echo("t2_bs1", 8'h08, 8'h08, 2);
    send_echo("t2_bs2", 8'h08, 8'h08, 1);
    send_echo("t2_Z", 8'h5A, 8'h5A, 2);
    send_echo("t2_CR", 8'h0D, 8'h0D, 2);
    exp_q = '{8'h41, 8'h5A, 8'h0D};
    expect_line("t2_line");

    // Overflow at DEPTH=4: "ABCDE" CR
    send_echo("t3_A", 8'h41, 8'h41, 1);
    send_echo("t3_B", 8'h42, 8'h42, 2);
    send_echo("t3_C", 8'h43, 8'h43, 3);
    send_echo("t3_D", 8'h44, 8'h44, 4);
    send(8'h45);
    chk("t3_E_drop", drop, 1);
    chk("t3_E_echo_vld", echo_valid, 1);
    chk("t3_E_echo_dat", echo_data, 8'h07);
    chk("t3_E_count", count, 4);
    send_echo("t3_CR", 8'h0D, 8'h0D, 4);
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D};
    expect_line("t3_line");

    // "XY" CR with stall, a 'Q' during the flush, then toggling ready
    lif.line_ready = 1'b0;
    send_echo("t4_X", 8'h58, 8'h58, 1);
    send_echo("t4_Y", 8'h59, 8'h59, 2);
    send_echo("t4_CR", 8'h0D, 8'h0D, 2);
    send(8'h51);
    chk("t4_Q_drop", drop, 1);
    chk("t4_Q_echo_vld", echo_valid, 0);
    chk("t4_Q_count", count, 2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t4_stall_dat%0d", i), lif.line_data, 8'h58);
      chk($sformatf("t4_stall_last%0d", i), lif.line_last, 0);
      chk($sformatf("t4_stall_vld%0d", i), lif.line_valid, 1);
      if (i < 2) tick();
    end
    exp_q = '{8'h58, 8'h59, 8'h0D};
    begin
      int idx = 0;
      int cyc = 0;
      while (idx < 3 && cyc < 20) begin
        lif.line_ready = cyc[0];
        chk($sformatf("t4_tog_vld%0d", cyc), lif.line_valid, 1);
        chk($sformatf("t4_tog_dat%0d", cyc), lif.line_data, exp_q[idx]);
        chk($sformatf("t4_tog_last%0d", cyc), lif.line_last, (idx == 2) ? 1 : 0);
        tick();
        if (cyc[0]) idx++;
        cyc++;
      end
      chk("t4_tog_beats", idx, 3);
    end
    chk("t4_done_vld", lif.line_valid, 0);
    chk("t4_done_count", count, 0);

    // CR alone: single terminator beat, and 'Q' must not appear
    send_echo("t5_CR", 8'h0D, 8'h0D, 0);
    exp_q = '{8'h0D};
    expect_line("t5_line");

    // Reset mid-flush
    lif.line_ready = 1'b0;
    send_echo("t6_A", 8'h41, 8'h41, 1);
    send_echo("t6_B", 8'h42, 8'h42, 2);
    send_echo("t6_CR", 8'h0D, 8'h0D, 2);
    chk("t6_pre_vld", lif.line_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_vld", lif.line_valid, 0);
    chk("t6_async_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_post_count", count, 0);
    chk("t6_post_busy", busy, 0);
    send_echo("t6_K", 8'h4B, 8'h4B, 1);
    send_echo("t6_CR2", 8'h0D, 8'h0D, 1);
    exp_q = '{8'h4B, 8'h0D};
    expect_line("t6_line");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/kbd_line_ctrl.md
# kbd_line_ctrl

Line-edit controller placed after the PS/2 keyboard wrapper. It consumes the decoded ASCII stream (`char_data`/`char_ready`) and assembles characters into a line buffer, handling backspace. On Enter it streams the completed line to a downstream consumer over a valid/ready handshake, and it produces a one-byte echo stream for the on-screen console.

## Interface
Parameters:
- `DEPTH`, 32: maximum printable characters per line, not counting the terminator; ≥2.
- `CW`, $clog2(DEPTH+1): width of the character count.

Ports:
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `char_data`  in  8: ASCII code from the keyboard wrapper.
- `char_ready`  in  1: one-cycle strobe; `char_data` is valid in that cycle.
- `echo_data`  out  8: byte to display.
- `echo_valid`  out  1: one-cycle strobe qualifying `echo_data`.
- `line_data`  out  8: output line byte.
- `line_valid`  out  1: output byte available.
- `line_ready`  in  1: consumer accepts the byte when valid and ready are both high.
- `line_last`  out  1: marks the terminator byte (0x0D).
- `busy`  out  1: high while a line is streaming out.
- `drop`  out  1: one-cycle strobe when an input character is discarded.
- `count`  out  CW: current number of characters in the buffer.

## Operation
- States:
  - EDIT (reset state).
  - FLUSH.
- EDIT, on `char_ready`:
  - Printable character (0x20–0x7E) with `count`<DEPTH: write it to `buf[count]`, increment `count`, echo the character.
  - Printable character with `count`==DEPTH: discard it, pulse `drop`, echo BEL (0x07).
  - 0x08 (BS) with `count`>0: decrement `count`, echo 0x08.
  - 0x08 with `count`==0: no effect and no echo.
  - 0x0D (CR): echo 0x0D, go to FLUSH, clear `rd_ptr`.
  - Any other code: ignored silently, with no drop and no echo.
- FLUSH:
  - Emit `buf[0..count-1]`, then the terminator 0x0D with `line_last`=1.
  - `rd_ptr` advances only on a handshake.
  - On the handshake of the terminator: clear `count`, go to EDIT.
  - An empty line emits only the terminator.
  - `char_ready` in FLUSH: the character is discarded, `drop` pulses, and there is no echo.
- Output muxing:
  - `line_data` = `buf[rd_ptr]` when `rd_ptr`<`count`, otherwise 0x0D.
  - `line_last` = (`rd_ptr`==`count`) && `line_valid`.
  - `line_valid` = (state==FLUSH).
  - `busy` = (state==FLUSH).
- Width rules:
  - `count` and `rd_ptr` are CW bits wide.
  - `count` never exceeds DEPTH and never underflows.
  - The buffer is not cleared on reset; only `count` is.

## Timing
- Reset values: `echo_data`=0, `echo_valid`=0, `line_valid`=0, `line_last`=0, `line_data`=0x0D, `busy`=0, `drop`=0, `count`=0, state=EDIT.
- Reset is asynchronous:
  - Asserting `reset_n` mid-FLUSH drops `line_valid` immediately.
  - The partial line is abandoned.
- Echo and drop latency: `echo_valid`/`echo_data` and `drop` are registered and appear in cycle t+1 for a `char_ready` in cycle t.
- The `count` update is visible at t+1.
- For a CR in cycle t: state is FLUSH and `line_valid`=1 from t+1.
- Handshake throughput: one byte per cycle while `line_ready`=1. A line of N characters completes in N+1 accepted beats.
- Stall rule: while `line_valid`=1 and `line_ready`=0, `line_data` and `line_last` hold stable.
- Terminator accepted in cycle t:
  - `line_valid`=0 and `count`=0 at t+1.
  - A `char_ready` in cycle t is still dropped.
  - A `char_ready` at t+1 is processed in EDIT.
- Back-to-back `char_ready` strobes in consecutive cycles are each processed; no rate limit is imposed.

## Structure
- Package `kbd_pkg` holds:
  - The ASCII constants `ASC_BS`=0x08, `ASC_CR`=0x0D, `ASC_BEL`=0x07, `ASC_SP`=0x20, `ASC_DEL`=0x7F.
  - The state enum `line_state_t` {EDIT, FLUSH}.
  - A function `is_printable(byte)`.
- Sub-module `kbd_line_buf`: DEPTH×8 register array with one synchronous write port (`we`, `waddr`, `wdata`) and one asynchronous read port. It is instantiated once.
- The FSM, counters, echo register and output mux live in `kbd_line_ctrl`.

## Test plan
- Type "AB", CR, with `line_ready`=1:
  - Echoes 0x41, 0x42, 0x0D, each one cycle after its strobe.
  - Line output is 0x41, 0x42, 0x0D on consecutive cycles, with `line_last` only on 0x0D.
  - `count` returns to 0.
- Type "ABC", BS, BS, "Z", CR:
  - Echoes include two 0x08 bytes.
  - Line output is 0x41, 0x5A, 0x0D.
  - A BS at `count`=0 produces no echo.
- With DEPTH=4, type "ABCDE", CR:
  - 'E' gives `drop`=1 and echo 0x07; `count` stays 4.
  - Line output is 0x41–0x44, then 0x0D.
- Type "XY", CR, with `line_ready` low for 3 cycles, then toggling:
  - `line_data` holds 0x58 while stalled.
  - No byte is skipped or duplicated.
  - A 'Q' strobed during FLUSH gives `drop`=1 and is absent from the next line.
- Type CR alone: a single beat of 0x0D with `line_last`=1.
- Assert `reset_n` low mid-FLUSH: `line_valid` goes to 0 asynchronously, `count`=0 and state is EDIT after release. The next line "K", CR outputs 0x4B, 0x0D.
